// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, reset PC default and FSM encodings for the fetch stage
package if_fetch_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int ByteBus     = 8;
  localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_ISSUE   = 1'b0,
    S_PRESENT = 1'b1
  } state_t;
endpackage

// File: rtl/if_icache.sv
// rtl/if_icache.sv - direct-mapped one-word-per-line instruction cache (tag/data arrays, lookup + fill)
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [InstAddrBus-1:0] lookup_addr,
  output logic                   hit,
  output logic [InstBus-1:0]     hit_data,
  input  logic                   fill_en,
  input  logic [InstAddrBus-1:0] fill_addr,
  input  logic [InstBus-1:0]     fill_data
);
  localparam int IW = $clog2(LINES);
  localparam int TW = InstAddrBus - IW - 2;

  logic [LINES-1:0]   valid;
  logic [TW-1:0]      tags [LINES];
  logic [InstBus-1:0] data [LINES];
  logic [IW-1:0]      lidx;
  logic [IW-1:0]      fidx;
  logic               unused_bits;

  assign lidx        = lookup_addr[IW+1:2];
  assign fidx        = fill_addr[IW+1:2];
  assign hit         = valid[lidx] && (tags[lidx] == lookup_addr[InstAddrBus-1:IW+2]);
  assign hit_data    = data[lidx];
  assign unused_bits = ^{lookup_addr[1:0], fill_addr[1:0]};

  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fidx] <= fill_addr[InstAddrBus-1:IW+2];
      data[fidx] <= fill_data;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - IF stage: byte-serial instruction fetch over the shared 8-bit port
// Define IF_ICACHE_EN to add the one-word direct-mapped instruction cache.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int                     ICACHE_LINES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   br,
  input  logic [InstAddrBus-1:0] br_addr,
  input  logic                   stall,
  input  logic                   mem_busy,
  input  logic [ByteBus-1:0]     mem_din,
  output logic [InstAddrBus-1:0] mem_a,
  output logic                   mem_rd_en,
  output logic [InstAddrBus-1:0] if_pc,
  output logic [InstBus-1:0]     if_inst,
  output logic                   if_valid
);
  state_t                 state, state_nxt;
  logic [InstAddrBus-1:0] pc;
  logic [2:0]             k;
  logic [1:0]             cap_idx;
  logic                   inflight;
  logic [23:0]            bbuf;
  logic                   issue;
  logic                   cap_last;
  logic                   handshake;
  logic                   hit;
  logic                   hit_take;
  logic [InstBus-1:0]     hit_data;
  logic [InstBus-1:0]     fill_word;

  assign cap_last  = (state == S_ISSUE) && inflight && (cap_idx == 2'd3);
  assign handshake = (state == S_PRESENT) && if_valid && !stall;
  assign hit_take  = (state == S_ISSUE) && (k == 3'd0) && hit;
  assign fill_word = {mem_din, bbuf};

`ifdef IF_ICACHE_EN
  if_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_addr(pc),
    .hit        (hit),
    .hit_data   (hit_data),
    .fill_en    (cap_last && !br),
    .fill_addr  (pc),
    .fill_data  (fill_word)
  );
`else
  logic unused_cfg;
  assign hit        = 1'b0;
  assign hit_data   = '0;
  assign unused_cfg = (ICACHE_LINES > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ISSUE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (br) begin
      state_nxt = S_ISSUE;
    end else begin
      case (state)
        S_ISSUE:   if (hit_take || cap_last) state_nxt = S_PRESENT;
        S_PRESENT: if (handshake) state_nxt = S_ISSUE;
        default:   state_nxt = S_ISSUE;
      endcase
    end
  end

  // Request is combinational so mem_busy arbitrates the very cycle it is raised.
  always_comb begin
    issue     = rst_n && (state == S_ISSUE) && (k < 3'd4) && !mem_busy && !hit_take;
    mem_rd_en = issue;
    mem_a     = rst_n ? (pc + {29'd0, k}) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      k        <= 3'd0;
      cap_idx  <= 2'd0;
      inflight <= 1'b0;
      bbuf     <= '0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_valid <= 1'b0;
    end else if (br) begin
      // The byte requested this cycle comes back next cycle and is dropped via inflight.
      pc       <= br_addr;
      k        <= 3'd0;
      cap_idx  <= 2'd0;
      inflight <= 1'b0;
      if_valid <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) k <= k + 3'd1;
      if (inflight) begin
        cap_idx <= cap_idx + 2'd1;
        case (cap_idx)
          2'd0:    bbuf[7:0]   <= mem_din;
          2'd1:    bbuf[15:8]  <= mem_din;
          2'd2:    bbuf[23:16] <= mem_din;
          default: ;
        endcase
      end
      if (cap_last) begin
        if_inst  <= fill_word;
        if_pc    <= pc;
        if_valid <= 1'b1;
      end else if (hit_take) begin
        if_inst  <= hit_data;
        if_pc    <= pc;
        if_valid <= 1'b1;
      end
      if (handshake) begin
        if_valid <= 1'b0;
        pc       <= pc + 32'd4;
        k        <= 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch with byte memory model and pc scoreboard
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_addr = '0;
  logic        stall = 1'b0;
  logic        mem_busy = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_a;
  logic        mem_rd_en;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb [$];
  logic [31:0] sb_exp;

  if_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .br       (br),
    .br_addr  (br_addr),
    .stall    (stall),
    .mem_busy (mem_busy),
    .mem_din  (mem_din),
    .mem_a    (mem_a),
    .mem_rd_en(mem_rd_en),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_valid (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w0;
    w0 = 32'h0000_0513;
    if (a[31:2] == 30'd0) return w0[8*a[1:0] +: 8];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Byte memory: data for the address requested in cycle N appears in cycle N+1.
  always @(posedge clk) begin
    mem_din <= mem_rd_en ? mem_byte(mem_a) : 8'($urandom);
  end

  // Scoreboard: expected pc sequence is pushed on reset/branch/handshake, popped on handshake.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      sb.delete();
      sb.push_back(32'h0);
    end else if (br) begin
      sb.delete();
      sb.push_back(br_addr);
    end else if (if_valid && !stall) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_empty: handshake pc %h with nothing expected", if_pc);
      end else begin
        sb_exp = sb.pop_front();
        if (if_pc !== sb_exp || if_inst !== word(sb_exp)) begin
          miscompares++;
          $display("FAIL sb_word: got pc %h inst %h want pc %h inst %h", if_pc, if_inst, sb_exp, word(sb_exp));
        end
        sb.push_back(sb_exp + 32'd4);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (!if_valid && cyc < limit) begin
      step();
      cyc++;
    end
    if (!if_valid) $display("note: if_valid timeout after %0d cycles", cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (mem_rd_en !== 1'b0 || mem_a !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outs: got rd %b a %h v %b pc %h inst %h want all zero", mem_rd_en, mem_a, if_valid, if_pc, if_inst);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      vectors++;
      if (mem_a !== 32'(c) || mem_rd_en !== 1'b1) begin
        miscompares++;
        $display("FAIL first_issue: cycle %0d got a %h rd %b want a %h rd 1", c, mem_a, mem_rd_en, c);
      end
    end
    step();
    vectors++;
    if (if_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL cycle4: got v %b rd %b want v 0 rd 0", if_valid, mem_rd_en);
    end
    step();
    vectors++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0000_0513) begin
      miscompares++;
      $display("FAIL first_word: got v %b pc %h inst %h want v 1 pc 0 inst 00000513", if_valid, if_pc, if_inst);
    end
    step();
    vectors++;
    if (if_valid !== 1'b0 || mem_a !== 32'h4 || mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL next_fetch: got v %b a %h rd %b want v 0 a 4 rd 1", if_valid, mem_a, mem_rd_en);
    end
  endtask

  task automatic test_mem_busy();
    int cyc;
    step();
    vectors++;
    if (mem_a !== 32'h5 || mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_b1: got a %h rd %b want a 5 rd 1", mem_a, mem_rd_en);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_busy = 1'b1;
      #1;
      vectors++;
      if (mem_rd_en !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_rd: cycle %0d got rd %b want 0", i, mem_rd_en);
      end
    end
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    vectors++;
    if (mem_a !== 32'h6 || mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_resume: got a %h rd %b want a 6 rd 1", mem_a, mem_rd_en);
    end
    wait_valid(20, cyc);
    vectors++;
    if (cyc !== 3 || if_pc !== 32'h4 || if_inst !== word(32'h4)) begin
      miscompares++;
      $display("FAIL busy_word: got cyc %0d pc %h inst %h want cyc 3 pc 4 inst %h", cyc, if_pc, if_inst, word(32'h4));
    end
  endtask

  task automatic test_stall();
    int cyc;
    @(negedge clk);
    stall = 1'b1;
    #1;
    wait_valid(20, cyc);
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL stall_lat: got %0d want 5", cyc);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      vectors++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== word(32'h8) || mem_rd_en !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: cycle %0d got v %b pc %h inst %h rd %b want v 1 pc 8 inst %h rd 0",
                 i, if_valid, if_pc, if_inst, mem_rd_en, word(32'h8));
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    step();
    vectors++;
    if (if_valid !== 1'b0 || mem_a !== 32'hC || mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got v %b a %h rd %b want v 0 a c rd 1", if_valid, mem_a, mem_rd_en);
    end
  endtask

  task automatic test_branch();
    int cyc;
    @(negedge clk);
    @(negedge clk);
    br      = 1'b1;
    br_addr = 32'h100;
    @(negedge clk);
    br = 1'b0;
    #1;
    vectors++;
    if (mem_a !== 32'h100 || mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL br_issue: got a %h rd %b want a 100 rd 1", mem_a, mem_rd_en);
    end
    wait_valid(20, cyc);
    vectors++;
    if (cyc !== 5 || if_pc !== 32'h100 || if_inst !== word(32'h100)) begin
      miscompares++;
      $display("FAIL br_word: got cyc %0d pc %h inst %h want cyc 5 pc 100 inst %h", cyc, if_pc, if_inst, word(32'h100));
    end
  endtask

  task automatic test_wrap();
    int cyc;
    @(negedge clk);
    br       = 1'b1;
    br_addr  = 32'hFFFF_FFFC;
    mem_busy = 1'b1;
    @(negedge clk);
    br       = 1'b0;
    mem_busy = 1'b0;
    #1;
    vectors++;
    if (mem_a !== 32'hFFFF_FFFC || mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_issue: got a %h rd %b want a fffffffc rd 1", mem_a, mem_rd_en);
    end
    wait_valid(20, cyc);
    vectors++;
    if (cyc !== 5 || if_pc !== 32'hFFFF_FFFC || if_inst !== word(32'hFFFF_FFFC)) begin
      miscompares++;
      $display("FAIL wrap_word: got cyc %0d pc %h inst %h want cyc 5 pc fffffffc inst %h",
               cyc, if_pc, if_inst, word(32'hFFFF_FFFC));
    end
    step();
    vectors++;
    if (mem_a !== 32'h0 || if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_next: got a %h v %b want a 0 v 0", mem_a, if_valid);
    end
`ifndef IF_ICACHE_EN
    vectors++;
    if (mem_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_rd: got %b want 1", mem_rd_en);
    end
`endif
  endtask

`ifdef IF_ICACHE_EN
  task automatic test_icache();
    int cyc;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      br      = 1'b1;
      br_addr = 32'h40;
      @(negedge clk);
      br = 1'b0;
      #1;
      if (pass == 1) begin
        vectors++;
        if (mem_rd_en !== 1'b0) begin
          miscompares++;
          $display("FAIL icache_rd: got %b want 0", mem_rd_en);
        end
      end
      wait_valid(20, cyc);
      vectors++;
      if (cyc !== (pass == 0 ? 5 : 1) || if_pc !== 32'h40 || if_inst !== word(32'h40)) begin
        miscompares++;
        $display("FAIL icache_word: pass %0d got cyc %0d pc %h inst %h want cyc %0d pc 40 inst %h",
                 pass, cyc, if_pc, if_inst, (pass == 0 ? 5 : 1), word(32'h40));
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mem_busy();
    test_stall();
    test_branch();
    test_wrap();
`ifdef IF_ICACHE_EN
    test_icache();
`endif
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
